// File: rtl/riio_bank_pwr_seq.sv
// Pad-ring IO supply bank sequencer: ordered power-up (enable, supply-good, settle, release) and reverse power-down.
// Optional WAIT_OK timeout is compiled in with `define RIIO_SEQ_TIMEOUT_EN.
module riio_bank_pwr_seq #(
  parameter  int N_BANKS     = 4,
  parameter  int SETTLE_CYC  = 64,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int BW          = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_up_req,
  input  logic               pwr_dn_req,
  input  logic [N_BANKS-1:0] vddq_ok,
  output logic [N_BANKS-1:0] bank_en,
  output logic [N_BANKS-1:0] bank_iso,
  output logic               busy,
  output logic               all_on,
  output logic               err,
  output logic [BW-1:0]      err_bank
);

  if (N_BANKS < 1 || N_BANKS > 16 || SETTLE_CYC < 1 || SETTLE_CYC > 255 ||
      TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_chk
    $error("riio_bank_pwr_seq: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_OFF, S_EN, S_WAIT_OK, S_SETTLE, S_RELEASE, S_ON, S_ISO, S_DIS, S_ERROR
  } state_t;

  state_t             state_q;
  logic [BW-1:0]      idx_q;
  logic [7:0]         cnt_q;
  logic [N_BANKS-1:0] ok_meta_q, ok_s_q;
  logic [N_BANKS-1:0] bank_en_q, bank_iso_q;
  logic               busy_q, all_on_q, err_q;
  logic [BW-1:0]      err_bank_q;
`ifdef RIIO_SEQ_TIMEOUT_EN
  logic [15:0]        tmo_q;
`endif

  function automatic logic [BW-1:0] lowest_low(input logic [N_BANKS-1:0] v);
    lowest_low = '0;
    for (int unsigned i = N_BANKS; i > 0; i--) begin
      if (!v[i-1]) lowest_low = BW'(i - 1);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_meta_q <= '0;
      ok_s_q    <= '0;
    end else begin
      ok_meta_q <= vddq_ok;
      ok_s_q    <= ok_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      idx_q      <= '0;
      cnt_q      <= '0;
      bank_en_q  <= '0;
      bank_iso_q <= '1;
      busy_q     <= 1'b0;
      all_on_q   <= 1'b0;
      err_q      <= 1'b0;
      err_bank_q <= '0;
`ifdef RIIO_SEQ_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_OFF: begin
          if (pwr_up_req && !pwr_dn_req) begin
            state_q <= S_EN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_EN: begin
          if (pwr_dn_req) begin
            state_q <= S_ISO;
          end else begin
            bank_en_q[idx_q] <= 1'b1;
            state_q          <= S_WAIT_OK;
`ifdef RIIO_SEQ_TIMEOUT_EN
            tmo_q            <= '0;
`endif
          end
        end
        S_WAIT_OK: begin
          if (pwr_dn_req) begin
            state_q <= S_ISO;
          end else if (ok_s_q[idx_q]) begin
            state_q <= S_SETTLE;
            cnt_q   <= 8'(SETTLE_CYC - 1);
          end
`ifdef RIIO_SEQ_TIMEOUT_EN
          else if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
            // Supply never came good: isolate everything, leave the switch on until shutdown.
            state_q    <= S_ERROR;
            bank_iso_q <= '1;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            if (!err_q) err_bank_q <= idx_q;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        S_SETTLE: begin
          if (pwr_dn_req) begin
            state_q <= S_ISO;
          end else if (cnt_q == 8'd0) begin
            state_q <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RELEASE: begin
          bank_iso_q[idx_q] <= 1'b0;
          if (idx_q == BW'(N_BANKS - 1)) begin
            state_q  <= S_ON;
            busy_q   <= 1'b0;
            all_on_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_EN;
          end
        end
        S_ON: begin
          // A supply fault outranks a simultaneous power-down request.
          if (!(&ok_s_q)) begin
            state_q    <= S_ERROR;
            bank_iso_q <= '1;
            all_on_q   <= 1'b0;
            err_q      <= 1'b1;
            if (!err_q) err_bank_q <= lowest_low(ok_s_q);
          end else if (pwr_dn_req) begin
            state_q  <= S_ISO;
            idx_q    <= BW'(N_BANKS - 1);
            all_on_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_ISO: begin
          bank_iso_q[idx_q] <= 1'b1;
          state_q           <= S_DIS;
        end
        S_DIS: begin
          bank_en_q[idx_q] <= 1'b0;
          if (idx_q == '0) begin
            state_q <= S_OFF;
            busy_q  <= 1'b0;
          end else begin
            idx_q   <= idx_q - 1'b1;
            state_q <= S_ISO;
          end
        end
        S_ERROR: begin
          if (pwr_dn_req) begin
            state_q <= S_ISO;
            idx_q   <= BW'(N_BANKS - 1);
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign bank_en  = bank_en_q;
  assign bank_iso = bank_iso_q;
  assign busy     = busy_q;
  assign all_on   = all_on_q;
  assign err      = err_q;
  assign err_bank = err_bank_q;

endmodule

// File: tb/tb_riio_bank_pwr_seq.sv
// Directed bench for riio_bank_pwr_seq (N_BANKS=2, SETTLE_CYC=4, TIMEOUT_CYC=20) with an expected-value queue.
module tb_riio_bank_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n, up, dn;
  logic [1:0] ok, en, iso;
  logic       busy, all_on, err;
  logic [0:0] eb;

  always #5 clk = ~clk;

  riio_bank_pwr_seq #(
    .N_BANKS    (2),
    .SETTLE_CYC (4),
    .TIMEOUT_CYC(20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up_req(up),
    .pwr_dn_req(dn),
    .vddq_ok   (ok),
    .bank_en   (en),
    .bank_iso  (iso),
    .busy      (busy),
    .all_on    (all_on),
    .err       (err),
    .err_bank  (eb)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Packed observation: {bank_en, bank_iso, busy, all_on, err, err_bank}
  function automatic logic [7:0] pk(input logic [1:0] e, input logic [1:0] i,
                                    input logic b, input logic a, input logic r, input logic k);
    return {e, i, b, a, r, k};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] obs;
    obs = {en, iso, busy, all_on, err, eb};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_after(input int n, input string tag, input logic [7:0] v);
    push_exp(tag, v);
    cyc(n);
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    up    = 1'b0;
    dn    = 1'b0;
    ok    = 2'b11;
    cyc(3);
    rst_n = 1'b1;
    expect_after(1, "reset", pk(2'b00, 2'b11, 0, 0, 0, 0));
    cyc(2);

    // Full power-up with both supplies good
    up = 1'b1;
    expect_after(1, "up_en_state",  pk(2'b00, 2'b11, 1, 0, 0, 0));
    up = 1'b0;
    expect_after(1, "up_en0",       pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(5, "up_settle0",   pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(1, "up_rel0",      pk(2'b01, 2'b10, 1, 0, 0, 0));
    expect_after(1, "up_en1",       pk(2'b11, 2'b10, 1, 0, 0, 0));
    expect_after(5, "up_settle1",   pk(2'b11, 2'b10, 1, 0, 0, 0));
    expect_after(1, "up_on",        pk(2'b11, 2'b00, 0, 1, 0, 0));
    expect_after(3, "on_hold",      pk(2'b11, 2'b00, 0, 1, 0, 0));

    // Power-down from ON
    dn = 1'b1;
    expect_after(1, "dn_start",     pk(2'b11, 2'b00, 1, 0, 0, 0));
    expect_after(1, "dn_iso1",      pk(2'b11, 2'b10, 1, 0, 0, 0));
    expect_after(1, "dn_dis1",      pk(2'b01, 2'b10, 1, 0, 0, 0));
    expect_after(1, "dn_iso0",      pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(1, "dn_off",       pk(2'b00, 2'b11, 0, 0, 0, 0));

    // Both requests in OFF: down wins
    up = 1'b1;
    expect_after(3, "both_off",     pk(2'b00, 2'b11, 0, 0, 0, 0));

    // Abort during SETTLE of bank 1
    dn = 1'b0;
    expect_after(12, "ab_settle1",  pk(2'b11, 2'b10, 1, 0, 0, 0));
    dn = 1'b1;
    up = 1'b0;
    expect_after(1, "ab_iso1",      pk(2'b11, 2'b10, 1, 0, 0, 0));
    expect_after(1, "ab_no_rel1",   pk(2'b11, 2'b10, 1, 0, 0, 0));
    expect_after(1, "ab_dis1",      pk(2'b01, 2'b10, 1, 0, 0, 0));
    expect_after(1, "ab_iso0",      pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(1, "ab_off",       pk(2'b00, 2'b11, 0, 0, 0, 0));

    // Fault in ON on bank 1
    dn = 1'b0;
    up = 1'b1;
    expect_after(15, "f_on",        pk(2'b11, 2'b00, 0, 1, 0, 0));
    ok = 2'b01;
    expect_after(2, "f_sync",       pk(2'b11, 2'b00, 0, 1, 0, 0));
    expect_after(1, "f_err",        pk(2'b11, 2'b11, 0, 0, 1, 1));
    expect_after(4, "f_err_hold",   pk(2'b11, 2'b11, 0, 0, 1, 1));
    dn = 1'b1;
    up = 1'b0;
    expect_after(1, "f_dn_start",   pk(2'b11, 2'b11, 1, 0, 1, 1));
    expect_after(2, "f_dis1",       pk(2'b01, 2'b11, 1, 0, 1, 1));
    expect_after(2, "f_off",        pk(2'b00, 2'b11, 0, 0, 1, 1));

    // Asynchronous reset clears the sticky fault
    rst_n = 1'b0;
    #1;
    push_exp("async_rst_err", pk(2'b00, 2'b11, 0, 0, 0, 0));
    check_out();
    cyc(2);
    rst_n = 1'b1;
    dn    = 1'b0;
    ok    = 2'b10;
    cyc(3);

    // Bank 0 supply never comes good
    up = 1'b1;
    expect_after(2, "t_wait",       pk(2'b01, 2'b11, 1, 0, 0, 0));
`ifdef RIIO_SEQ_TIMEOUT_EN
    expect_after(19, "t_pre",       pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(1, "t_err",        pk(2'b01, 2'b11, 0, 0, 1, 0));
`else
    expect_after(20, "t_no_tmo",    pk(2'b01, 2'b11, 1, 0, 0, 0));
    expect_after(1000, "t_waiting", pk(2'b01, 2'b11, 1, 0, 0, 0));
`endif

    // Reset mid-sequence forces everything off and isolated at once
    rst_n = 1'b0;
    #1;
    push_exp("async_rst_mid", pk(2'b00, 2'b11, 0, 0, 0, 0));
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
